// File: rtl/mdu_iter_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_if
// Description : Request/result bundle between the EX stage and mdu_iter.
//               master (pipeline) drives start/op/cancel/a/b,
//               slave (mdu_iter) drives busy/done/hi/lo.
// Ports       : start, op[3:0], cancel, a/b[WIDTH-1:0]   -> unit
//               busy, done, hi/lo[WIDTH-1:0]              <- unit
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic             cancel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, cancel, a, b, input  busy, done, hi, lo);
    modport slave  (input  start, op, cancel, a, b, output busy, done, hi, lo);
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative multiply/divide unit with HI/LO registers.
//               Multiplies complete after MUL_LAT busy cycles; divides use a
//               radix-2 restoring divider (WIDTH iterations + 1 sign fix-up).
//               Optional multiply-accumulate ops (4..7) are built only when
//               the macro MDU_MACC_EN is defined; otherwise they are no-ops.
// Ports       : clk, reset_n (async, active low)
//               bus : mdu_iter_if.slave (start/op/cancel/a/b in,
//                                        busy/done/hi/lo out)
// Parameters  : WIDTH (>=4) operand width, MUL_LAT (>=1) multiply latency
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    mdu_iter_if.slave  bus
);
    localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] c_op_mult  = 4'd0;
    localparam logic [3:0] c_op_multu = 4'd1;
    localparam logic [3:0] c_op_div   = 4'd2;
    localparam logic [3:0] c_op_divu  = 4'd3;
    localparam logic [3:0] c_op_mthi  = 4'd8;
    localparam logic [3:0] c_op_mtlo  = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV_ITER, S_DIV_FIX} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_quo;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_dvsr;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
`ifdef MDU_MACC_EN
    logic               r_acc;
    logic               r_sub;
`endif

    // ---------------- request decode ----------------
    logic w_accept, w_signed, w_is_mul, w_is_div, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs;
    logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_product, w_mul_res;

    assign w_accept = bus.start & ~bus.cancel & ~r_busy & (r_state == S_IDLE);
    assign w_signed = ~bus.op[0];   // even op codes are the signed variants
`ifdef MDU_MACC_EN
    assign w_is_mul = (bus.op == c_op_mult) | (bus.op == c_op_multu) | (bus.op[3:2] == 2'b01);
`else
    assign w_is_mul = (bus.op == c_op_mult) | (bus.op == c_op_multu);
`endif
    assign w_is_div = (bus.op == c_op_div) | (bus.op == c_op_divu);

    // Sign-extending to 2*WIDTH lets one unsigned multiplier produce the
    // correct signed product modulo 2^(2*WIDTH).
    assign w_a_ext   = w_signed ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
    assign w_b_ext   = w_signed ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
    assign w_product = w_a_ext * w_b_ext;

    assign w_a_neg = w_signed & bus.a[WIDTH-1];
    assign w_b_neg = w_signed & bus.b[WIDTH-1];
    // -(-2^(WIDTH-1)) keeps the same bit pattern, which is the correct magnitude
    assign w_a_abs = w_a_neg ? -bus.a : bus.a;
    assign w_b_abs = w_b_neg ? -bus.b : bus.b;

    // ---------------- divider step ----------------
    logic [WIDTH:0]   w_rem_sh, w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_q_fix, w_r_fix;

    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvsr};
    assign w_fits   = ~w_trial[WIDTH];
    assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix  = r_neg_r ? -r_rem : r_rem;

    // ---------------- multiply completion value ----------------
`ifdef MDU_MACC_EN
    logic [2*WIDTH-1:0] w_hilo;
    assign w_hilo    = {r_hi, r_lo};
    // Accumulates against HI/LO as they stand at completion time.
    assign w_mul_res = r_acc ? (r_sub ? (w_hilo - r_prod) : (w_hilo + r_prod)) : r_prod;
`else
    assign w_mul_res = r_prod;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_prod     <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
`ifdef MDU_MACC_EN
            r_acc      <= 1'b0;
            r_sub      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_prod  <= w_product;
                            r_cnt   <= CNT_W'(MUL_LAT);
                            r_busy  <= 1'b1;
                            r_state <= S_MUL;
`ifdef MDU_MACC_EN
                            r_acc   <= bus.op[2];
                            r_sub   <= bus.op[1];
`endif
                        end else if (w_is_div) begin
                            r_rem      <= '0;
                            r_quo      <= w_a_abs;
                            r_dvsr     <= w_b_abs;
                            r_neg_q    <= w_a_neg ^ w_b_neg;
                            r_neg_r    <= w_a_neg;
                            r_div_zero <= (bus.b == '0);
                            r_cnt      <= CNT_W'(WIDTH);
                            r_busy     <= 1'b1;
                            r_state    <= S_DIV_ITER;
                        end else if (bus.op == c_op_mthi) begin
                            r_hi <= bus.a;
                        end else if (bus.op == c_op_mtlo) begin
                            r_lo <= bus.a;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == CNT_W'(1)) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIV_ITER: begin
                    if (bus.cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_fits};
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_DIV_FIX;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_DIV_FIX: begin
                    if (bus.cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        // A zero divisor leaves the dividend in the remainder
                        // naturally; only the quotient needs forcing.
                        r_lo    <= r_div_zero ? {WIDTH{1'b1}} : w_q_fix;
                        r_hi    <= w_r_fix;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Self-checking bench for mdu_iter (WIDTH=32, MUL_LAT=5).
//               Directed vector table, hand-written multi-cycle sequences
//               (cancel, reset, back-to-back) and random ops checked against
//               an arithmetic reference model. Honors MDU_MACC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;
    localparam int W   = 32;
    localparam int LAT = 5;

    logic clk = 1'b0;
    logic reset_n;

    mdu_iter_if #(.WIDTH(W)) bus ();
    mdu_iter #(.WIDTH(W), .MUL_LAT(LAT)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi, m_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;
    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: applies an op to the architectural HI/LO using plain
    // arithmetic and returns the expected number of busy cycles.
    function automatic int model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              lat;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        lat = 0;
        case (op)
            4'd0: begin p = sa * sb; {m_hi, m_lo} = p; lat = LAT; end
            4'd1: begin p = ua * ub; {m_hi, m_lo} = p; lat = LAT; end
            4'd2, 4'd3: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else if (op == 4'd2) begin
                    p = sa / sb; m_lo = p[31:0];
                    p = sa % sb; m_hi = p[31:0];
                end else begin
                    p = ua / ub; m_lo = p[31:0];
                    p = ua % ub; m_hi = p[31:0];
                end
                lat = W + 1;
            end
            4'd4, 4'd5, 4'd6, 4'd7: begin
`ifdef MDU_MACC_EN
                if (op[0]) p = ua * ub;
                else       p = sa * sb;
                if (op[1]) {m_hi, m_lo} = {m_hi, m_lo} - p;
                else       {m_hi, m_lo} = {m_hi, m_lo} + p;
                lat = LAT;
`endif
            end
            4'd8: m_hi = a;
            4'd9: m_lo = a;
            default: ;
        endcase
        return lat;
    endfunction

    // Issue one op, measure busy length, check done pulse and result.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] ehi, input logic [31:0] elo,
                         input string nm);
        int nb;
        int nd;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nb = 0; nd = 0;
        while (bus.busy && nb < 200) begin
            nb++;
            if (bus.done) nd++;
            tick();
        end
        chk({nm, " busy_cycles"}, 64'(nb), 64'(lat));
        chk({nm, " done_early"}, 64'(nd), 64'd0);
        chk({nm, " done"}, {63'd0, bus.done}, {63'd0, (lat > 0)});
        chk({nm, " hi"}, {32'd0, bus.hi}, {32'd0, ehi});
        chk({nm, " lo"}, {32'd0, bus.lo}, {32'd0, elo});
        tick();
        chk({nm, " done_1cyc"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        int nb;
        int nd;
        int lat;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 4'd0; bus.cancel = 1'b0; bus.a = '0; bus.b = '0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("reset hi", {32'd0, bus.hi}, 64'd0);
        chk("reset lo", {32'd0, bus.lo}, 64'd0);
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        chk("reset done", {63'd0, bus.done}, 64'd0);

        // ---------------- directed vector table ----------------
        vecs.push_back(vec_t'{4'd0, 32'hFFFF_FFFD, 32'd7,         LAT,   32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back(vec_t'{4'd1, 32'hFFFF_FFFD, 32'd7,         LAT,   32'h0000_0006, 32'hFFFF_FFEB});
        vecs.push_back(vec_t'{4'd0, 32'h8000_0000, 32'h7FFF_FFFF, LAT,   32'hC000_0000, 32'h8000_0000});
        vecs.push_back(vec_t'{4'd2, 32'hFFFF_FFF9, 32'd2,         W + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back(vec_t'{4'd3, 32'h8000_0000, 32'd3,         W + 1, 32'h0000_0002, 32'h2AAA_AAAA});
        vecs.push_back(vec_t'{4'd3, 32'd100,       32'd0,         W + 1, 32'h0000_0064, 32'hFFFF_FFFF});
        vecs.push_back(vec_t'{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back(vec_t'{4'd2, 32'hFFFF_FFFB, 32'd0,         W + 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
        vecs.push_back(vec_t'{4'd2, 32'd7,         32'hFFFF_FFFE, W + 1, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back(vec_t'{4'd3, 32'hFFFF_FFFF, 32'd1,         W + 1, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back(vec_t'{4'd8, 32'h0000_1234, 32'd0,         0,     32'h0000_1234, 32'hFFFF_FFFF});
        vecs.push_back(vec_t'{4'd9, 32'h0000_5678, 32'd0,         0,     32'h0000_1234, 32'h0000_5678});
        vecs.push_back(vec_t'{4'd10, 32'hDEAD_BEEF, 32'd1,        0,     32'h0000_1234, 32'h0000_5678});
        vecs.push_back(vec_t'{4'd15, 32'hDEAD_BEEF, 32'd1,        0,     32'h0000_1234, 32'h0000_5678});
        for (int i = 0; i < vecs.size(); i++) begin
            void'(model_apply(vecs[i].op, vecs[i].a, vecs[i].b));
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].ehi, vecs[i].elo,
                  $sformatf("vec%0d", i));
        end

        // ---------------- cancel on divide busy cycle 10 ----------------
        bus.op = 4'd2; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        chk("cancel pre busy", {63'd0, bus.busy}, 64'd1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel busy", {63'd0, bus.busy}, 64'd0);
        chk("cancel done", {63'd0, bus.done}, 64'd0);
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) nd++;
            tick();
        end
        chk("cancel no completion", 64'(nd), 64'd0);
        chk("cancel hi", {32'd0, bus.hi}, 64'h1234);
        chk("cancel lo", {32'd0, bus.lo}, 64'h5678);

        // ---------------- start together with cancel ----------------
        bus.op = 4'd2; bus.a = 32'd9; bus.b = 32'd2; bus.start = 1'b1; bus.cancel = 1'b1;
        tick();
        chk("start+cancel div busy", {63'd0, bus.busy}, 64'd0);
        bus.op = 4'd8; bus.a = 32'hDEAD;
        tick();
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("start+cancel mthi busy", {63'd0, bus.busy}, 64'd0);
        chk("start+cancel mthi hi", {32'd0, bus.hi}, 64'h1234);

        // ---------------- cancel coinciding with multiply completion ----------------
        bus.op = 4'd0; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < LAT; k++) tick();
        chk("cancel@done pre busy", {63'd0, bus.busy}, 64'd1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        chk("cancel@done busy", {63'd0, bus.busy}, 64'd0);
        chk("cancel@done done", {63'd0, bus.done}, 64'd0);
        chk("cancel@done hi", {32'd0, bus.hi}, 64'h1234);
        chk("cancel@done lo", {32'd0, bus.lo}, 64'h5678);

        // ---------------- start while busy is ignored ----------------
        void'(model_apply(4'd3, 32'd50, 32'd7));
        bus.op = 4'd3; bus.a = 32'd50; bus.b = 32'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nb = 0;
        while (bus.busy && nb < 200) begin
            nb++;
            bus.start = (nb >= 2 && nb <= 5);
            bus.op = 4'd8; bus.a = 32'hDEAD;
            tick();
        end
        bus.start = 1'b0;
        chk("busy-start cycles", 64'(nb), 64'(W + 1));
        chk("busy-start done", {63'd0, bus.done}, 64'd1);
        chk("busy-start hi", {32'd0, bus.hi}, {32'd0, m_hi});
        chk("busy-start lo", {32'd0, bus.lo}, {32'd0, m_lo});

        // ---------------- accept in the cycle done is high ----------------
        void'(model_apply(4'd0, 32'd7, 32'd6));
        bus.op = 4'd0; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        nb = 0;
        while (bus.busy && nb < 200) begin nb++; tick(); end
        chk("b2b done", {63'd0, bus.done}, 64'd1);
        void'(model_apply(4'd9, 32'hABCD, 32'd0));
        bus.op = 4'd9; bus.a = 32'hABCD; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("b2b hi", {32'd0, bus.hi}, {32'd0, m_hi});
        chk("b2b lo", {32'd0, bus.lo}, {32'd0, m_lo});

        // ---------------- multiply-accumulate sequence ----------------
        void'(model_apply(4'd8, 32'd0, 32'd0));
        do_op(4'd8, 32'd0, 32'd0, 0, m_hi, m_lo, "macc mthi");
        void'(model_apply(4'd9, 32'hFFFF_FFFF, 32'd0));
        do_op(4'd9, 32'hFFFF_FFFF, 32'd0, 0, m_hi, m_lo, "macc mtlo");
`ifdef MDU_MACC_EN
        do_op(4'd5, 32'd1, 32'd1, LAT, 32'd1, 32'd0, "maddu");
        do_op(4'd6, 32'd1, 32'd1, LAT, 32'd0, 32'hFFFF_FFFF, "msub");
`else
        do_op(4'd5, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF, "maddu");
        do_op(4'd6, 32'd1, 32'd1, 0, 32'd0, 32'hFFFF_FFFF, "msub");
`endif
        void'(model_apply(4'd5, 32'd1, 32'd1));
        void'(model_apply(4'd6, 32'd1, 32'd1));

        // ---------------- randomized ops against the model ----------------
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            lat = model_apply(rop, ra, rb);
            do_op(rop, ra, rb, lat, m_hi, m_lo, $sformatf("rnd%0d op%0d", i, rop));
        end

        // ---------------- asynchronous reset during multiply ----------------
        do_op(4'd8, 32'hAAAA, 32'd0, 0, 32'hAAAA, m_lo, "pre-reset mthi");
        do_op(4'd9, 32'h5555, 32'd0, 0, 32'hAAAA, 32'h5555, "pre-reset mtlo");
        bus.op = 4'd0; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        chk("reset-mid pre busy", {63'd0, bus.busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("reset-mid hi", {32'd0, bus.hi}, 64'd0);
        chk("reset-mid lo", {32'd0, bus.lo}, 64'd0);
        chk("reset-mid busy", {63'd0, bus.busy}, 64'd0);
        chk("reset-mid done", {63'd0, bus.done}, 64'd0);
        tick();
        reset_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.done || bus.busy || bus.hi != 32'd0 || bus.lo != 32'd0) nd++;
        end
        chk("reset-mid no completion", 64'(nd), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multiply/divide unit for the EX stage, the successor to the fixed 32-bit MDU. It has configurable operand width and multiply latency. Division is a true iterative radix-2 restoring divider rather than a delayed single-cycle result. It adds multiply-accumulate ops, an abort input for exceptions/interrupts, and defined divide-by-zero/overflow results. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand and HI/LO width, ≥ 4.
- `MUL_LAT`, 5: multiply busy cycles, ≥ 1.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset; one clock.
- `start` in 1: qualifies `op` for one cycle.
- `op` in 4: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; others no-op.
- `cancel` in 1: abort in-flight op and block the current start (exception/interrupt).
- `a` in WIDTH: rs operand; also the MTHI/MTLO source.
- `b` in WIDTH: rt operand.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO take an op result.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States: IDLE, MUL, DIV_ITER, DIV_FIX.
- Accept: `start & !busy & !cancel` in IDLE.
  - `start` while busy, or with `cancel` high, is ignored entirely.
- MTHI/MTLO: write `a` into hi/lo at the accept edge. No busy, no done.
- MULT/MULTU and MADD/MSUB family:
  - At accept, register the 2·WIDTH product (signed or unsigned per op).
  - Go to MUL and load a counter with MUL_LAT.
  - When the counter expires, {hi,lo} ← product. MADD variants add it to {hi,lo}; MSUB variants subtract it from {hi,lo}, modulo 2^(2·WIDTH).
  - The {hi,lo} value used is the one current at completion, not at accept.
- DIV/DIVU:
  - At accept, latch |a|, |b| (signed ops) or a, b, plus the result signs. Go to DIV_ITER.
  - DIV_ITER runs WIDTH iterations. Each shifts in one dividend bit, trial-subtracts the divisor, and sets one quotient bit.
  - DIV_FIX applies signs: quotient negative if signs differ; remainder takes the dividend's sign.
  - Result: lo ← quotient, hi ← remainder.
- Divisor zero: lo = all ones, hi = a. This holds for signed and unsigned, with full latency.
- Signed overflow: a = −2^(WIDTH−1), b = −1 gives lo = a, hi = 0.
- `cancel` while busy: return to IDLE at the next edge. hi/lo are unchanged and `done` stays low.
- Reset: hi = 0, lo = 0, busy = 0, done = 0, state IDLE. This is immediate on `reset_n` low, including mid-operation.

## Timing
- `busy` is registered. It rises at the accept edge.
  - Multiply: high for MUL_LAT cycles.
  - Divide: high for WIDTH+1 cycles (WIDTH iterations + 1 fix-up), i.e. 33 at WIDTH=32.
- At the completion edge, hi/lo update, `busy` falls and `done` rises for exactly one cycle.
- A new `start` is accepted in the first cycle with `busy` low, including the cycle `done` is high.
- MTHI/MTLO results are visible the cycle after accept.
- `cancel` and completion on the same edge: cancel wins. No write, no done.

## Configuration
- `MDU_MACC_EN` defined: ops 4–7 (MADD/MADDU/MSUB/MSUBU) are implemented as above.
- `MDU_MACC_EN` undefined: ops 4–7 decode as no-ops. They are never accepted, `busy` stays low and hi/lo are untouched. The accumulate adder is not built.

## Test plan
- WIDTH=32, MUL_LAT=5. MULT a=0xFFFFFFFD (−3), b=7 → busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once.
- DIV a=−7, b=2 → busy 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=0x80000000, b=3 → lo=0x2AAAAAAA, hi=2.
- Divide by zero and overflow:
  - DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x64.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Cancel: MTHI 0x1234 and MTLO 0x5678, then DIV; assert `cancel` on busy cycle 10. Required: busy low the next cycle, hi/lo remain 0x1234/0x5678, no done. Also, `start` with `cancel` high → nothing is accepted.
- With `MDU_MACC_EN`: hi/lo=0/0xFFFFFFFF, then MADDU 1×1 → hi=1, lo=0; then MSUB 1×1 → hi=0, lo=0xFFFFFFFF. Without the macro, the same sequence leaves hi/lo=0/0xFFFFFFFF and busy never rises.
- Drop `reset_n` during MUL cycle 3 → hi, lo, busy, done go to 0 immediately; no completion follows after release.
